rob_commit_queue: RTL and testbench

// - Reorder buffer: the producer side of the register-file commit port. The register file

---
 rtl/rob_commit_queue.sv | 120 ++++++++++++
 tb/tb_rob_commit_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_queue.sv
// Reorder buffer: in-order allocation, out-of-order writeback, in-order single commit per cycle,
// with two combinational operand queries that also see same-cycle writeback data.
module rob_commit_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_WIDTH   = 5,
  parameter int ENTRY_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  input  logic [REG_WIDTH-1:0]   alloc_name,
  output logic                   alloc_ready,
  output logic [ENTRY_WIDTH-1:0] alloc_entry,
  input  logic                   wb_valid,
  input  logic [ENTRY_WIDTH-1:0] wb_entry,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  input  logic [ENTRY_WIDTH-1:0] qry1_entry,
  output logic                   qry1_ready,
  output logic [DATA_WIDTH-1:0]  qry1_data,
  input  logic [ENTRY_WIDTH-1:0] qry2_entry,
  output logic                   qry2_ready,
  output logic [DATA_WIDTH-1:0]  qry2_data,
  output logic                   rob_we,
  output logic [REG_WIDTH-1:0]   rob_namew,
  output logic [DATA_WIDTH-1:0]  rob_dataw,
  output logic [ENTRY_WIDTH-1:0] rob_entryw,
  output logic [ENTRY_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ENTRY_WIDTH;

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ENTRY_WIDTH:0] PTR_ONE = {{ENTRY_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            r_state [DEPTH];
  logic [REG_WIDTH-1:0]  r_name  [DEPTH];
  logic [DATA_WIDTH-1:0] r_data  [DEPTH];
  logic [ENTRY_WIDTH:0]  r_head;
  logic [ENTRY_WIDTH:0]  r_tail;

  logic [ENTRY_WIDTH-1:0] w_head_idx;
  logic [ENTRY_WIDTH-1:0] w_tail_idx;
  logic                   w_full;
  logic                   w_alloc_fire;
  logic                   w_wb_fire;
  logic                   w_commit_fire;

  // A query is answered from a finished entry, or forwarded from this cycle's writeback to a busy one.
  function automatic logic [DATA_WIDTH:0] f_query(
    input logic [1:0]            q_state,
    input logic [DATA_WIDTH-1:0] q_data,
    input logic                  q_wb_hit,
    input logic [DATA_WIDTH-1:0] q_wb_data
  );
    logic [DATA_WIDTH:0] v_res;
    case (q_state)
      ST_DONE: v_res = {1'b1, q_data};
      ST_BUSY: v_res = q_wb_hit ? {1'b1, q_wb_data} : {1'b0, {DATA_WIDTH{1'b0}}};
      default: v_res = {1'b0, {DATA_WIDTH{1'b0}}};
    endcase
    return v_res;
  endfunction

  assign w_head_idx    = r_head[ENTRY_WIDTH-1:0];
  assign w_tail_idx    = r_tail[ENTRY_WIDTH-1:0];
  assign w_full        = (w_head_idx == w_tail_idx) && (r_head[ENTRY_WIDTH] != r_tail[ENTRY_WIDTH]);
  assign w_alloc_fire  = alloc_valid && !w_full;
  assign w_wb_fire     = wb_valid && (r_state[wb_entry] == ST_BUSY);
  assign w_commit_fire = (r_state[w_head_idx] == ST_DONE);

  assign alloc_ready = !w_full;
  assign alloc_entry = w_tail_idx;
  assign count       = r_tail - r_head;

  assign {qry1_ready, qry1_data} = f_query(r_state[qry1_entry], r_data[qry1_entry],
                                           wb_valid && (wb_entry == qry1_entry), wb_data);
  assign {qry2_ready, qry2_data} = f_query(r_state[qry2_entry], r_data[qry2_entry],
                                           wb_valid && (wb_entry == qry2_entry), wb_data);

  // Alloc targets a FREE slot, wb a BUSY one and commit the DONE head, so the three never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_FREE;
        r_name[i]  <= {REG_WIDTH{1'b0}};
        r_data[i]  <= {DATA_WIDTH{1'b0}};
      end
      r_head     <= {(ENTRY_WIDTH+1){1'b0}};
      r_tail     <= {(ENTRY_WIDTH+1){1'b0}};
      rob_we     <= 1'b0;
      rob_namew  <= {REG_WIDTH{1'b0}};
      rob_dataw  <= {DATA_WIDTH{1'b0}};
      rob_entryw <= {ENTRY_WIDTH{1'b0}};
    end else begin
      if (w_alloc_fire) begin
        r_state[w_tail_idx] <= ST_BUSY;
        r_name[w_tail_idx]  <= alloc_name;
        r_tail              <= r_tail + PTR_ONE;
      end
      if (w_wb_fire) begin
        r_state[wb_entry] <= ST_DONE;
        r_data[wb_entry]  <= wb_data;
      end
      if (w_commit_fire) begin
        rob_we              <= 1'b1;
        rob_namew           <= r_name[w_head_idx];
        rob_dataw           <= r_data[w_head_idx];
        rob_entryw          <= w_head_idx;
        r_state[w_head_idx] <= ST_FREE;
        r_head              <= r_head + PTR_ONE;
      end else begin
        rob_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed bench: expected commits go into a scoreboard queue, a negedge monitor checks each rob_we pulse.
module tb_rob_commit_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_name;
  logic        alloc_ready;
  logic [2:0]  alloc_entry;
  logic        wb_valid;
  logic [2:0]  wb_entry;
  logic [31:0] wb_data;
  logic [2:0]  qry1_entry;
  logic        qry1_ready;
  logic [31:0] qry1_data;
  logic [2:0]  qry2_entry;
  logic        qry2_ready;
  logic [31:0] qry2_data;
  logic        rob_we;
  logic [4:0]  rob_namew;
  logic [31:0] rob_dataw;
  logic [2:0]  rob_entryw;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  rob_commit_queue dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_name(alloc_name),
    .alloc_ready(alloc_ready), .alloc_entry(alloc_entry),
    .wb_valid(wb_valid), .wb_entry(wb_entry), .wb_data(wb_data),
    .qry1_entry(qry1_entry), .qry1_ready(qry1_ready), .qry1_data(qry1_data),
    .qry2_entry(qry2_entry), .qry2_ready(qry2_ready), .qry2_data(qry2_data),
    .rob_we(rob_we), .rob_namew(rob_namew), .rob_dataw(rob_dataw),
    .rob_entryw(rob_entryw), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_commit(input logic [4:0] nm, input logic [31:0] d, input logic [2:0] e);
    exp_q.push_back({nm, d, e});
  endtask

  // Commit monitor: every rob_we pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (rob_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit actual=%0h/%0h/%0h required=none", rob_namew, rob_dataw, rob_entryw);
      end else begin
        chk("commit", {24'd0, rob_namew, rob_dataw, rob_entryw}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_name = 5'd0;
    wb_valid = 1'b0; wb_entry = 3'd0; wb_data = 32'd0;
    qry1_entry = 3'd0; qry2_entry = 3'd0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_entry", 64'(alloc_entry), 64'd0);
    chk("rst_rob_we", 64'(rob_we), 64'd0);
    chk("rst_rob_namew", 64'(rob_namew), 64'd0);
    step(); step();
    rst = 1'b0;

    // Fill all eight entries with names 1..8
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1;
      alloc_name  = 5'(i + 1);
      chk("alloc_entry", 64'(alloc_entry), 64'(i));
      step();
    end
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(alloc_ready), 64'd0);
    alloc_name = 5'd20;
    step();
    chk("ninth_dropped", 64'(count), 64'd8);
    alloc_valid = 1'b0;

    // Out-of-order writeback: entry2 first, head blocks
    wb_valid = 1'b1; wb_entry = 3'd2; wb_data = 32'hAA;
    step();
    wb_valid = 1'b0;
    chk("no_commit_e2", 64'(rob_we), 64'd0);
    step();
    chk("no_commit_e2b", 64'(rob_we), 64'd0);
    wb_valid = 1'b1; wb_entry = 3'd0; wb_data = 32'h11;
    expect_commit(5'd1, 32'h11, 3'd0);
    step();
    wb_valid = 1'b0;
    chk("wb_latency", 64'(rob_we), 64'd0);
    // Full with DONE head: alloc refused on the commit edge
    alloc_valid = 1'b1; alloc_name = 5'd9;
    chk("full_head_done_ready", 64'(alloc_ready), 64'd0);
    step();
    chk("commit0_we", 64'(rob_we), 64'd1);
    chk("after_commit_count", 64'(count), 64'd7);
    chk("after_commit_ready", 64'(alloc_ready), 64'd1);
    chk("wrap_alloc_entry", 64'(alloc_entry), 64'd0);
    step();
    alloc_valid = 1'b0;
    chk("e1_busy_no_we", 64'(rob_we), 64'd0);
    chk("wrap_alloc_count", 64'(count), 64'd8);
    chk("wrap_full_ready", 64'(alloc_ready), 64'd0);

    // entry1 completes: entries 1 and 2 commit back-to-back
    wb_valid = 1'b1; wb_entry = 3'd1; wb_data = 32'h22;
    expect_commit(5'd2, 32'h22, 3'd1);
    expect_commit(5'd3, 32'hAA, 3'd2);
    step();
    wb_valid = 1'b0;
    step();
    chk("b2b_first_we", 64'(rob_we), 64'd1);
    step();
    chk("b2b_second_we", 64'(rob_we), 64'd1);
    chk("head3_count", 64'(count), 64'd6);
    step();
    chk("e3_busy_no_we", 64'(rob_we), 64'd0);

    // Queries: same-cycle wb forward on BUSY entry3, FREE entry1 reads zero
    qry1_entry = 3'd3; qry2_entry = 3'd1;
    wb_valid = 1'b1; wb_entry = 3'd3; wb_data = 32'h55;
    #1;
    chk("qry1_fwd_ready", 64'(qry1_ready), 64'd1);
    chk("qry1_fwd_data", 64'(qry1_data), 64'h55);
    chk("qry2_free_ready", 64'(qry2_ready), 64'd0);
    chk("qry2_free_data", 64'(qry2_data), 64'd0);
    expect_commit(5'd4, 32'h55, 3'd3);
    step();
    // A second wb to the now-DONE entry must be ignored
    wb_data = 32'h99;
    #1;
    chk("qry1_done_data", 64'(qry1_data), 64'h55);
    step();
    wb_valid = 1'b0;
    #1;
    chk("qry1_freed_ready", 64'(qry1_ready), 64'd0);
    chk("after_e3_count", 64'(count), 64'd5);

    // Reset with five live entries (entry5 DONE, head entry4 BUSY)
    wb_valid = 1'b1; wb_entry = 3'd5; wb_data = 32'h66;
    step();
    wb_valid = 1'b0;
    qry1_entry = 3'd5;
    #1;
    chk("pre_rst_qry_ready", 64'(qry1_ready), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_we", 64'(rob_we), 64'd0);
    chk("mid_rst_ready", 64'(alloc_ready), 64'd1);
    chk("mid_rst_entry", 64'(alloc_entry), 64'd0);
    chk("mid_rst_qry", 64'(qry1_ready), 64'd0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_count", 64'(count), 64'd0);
    alloc_valid = 1'b1; alloc_name = 5'd7;
    chk("post_rst_entry", 64'(alloc_entry), 64'd0);
    step();
    alloc_valid = 1'b0;
    chk("post_rst_alloc_count", 64'(count), 64'd1);
    step();

    chk("pending_commits", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
